injection_sequencer: RTL and testbench

- Sequences one address-generator instance through a run of N memory-injection transactions.
- Pulses the generator's initialize and enable inputs, and issues each generated address as a valid/ready request to the memory port.
- Bounds the number of in-flight transactions, drains responses, and reports busy, done, error and progress to the control registers.

---
 rtl/injection_sequencer.sv | 126 ++++++++++++
 tb/tb_injection_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/injection_sequencer.sv
// injection_sequencer: drives one address generator through a run of memory-injection requests.
//
// Ports:
//   clock, resetn          clock and asynchronous active-low reset
//   start, abort           single-cycle run start / stop requests
//   transaction_count      requests in the run, latched on an accepted start
//   generator_initialize   one-cycle pulse loading the generator start value
//   generator_enable       advances the generator, asserted on each request handshake
//   generator_address      current registered generator output
//   request_valid/ready    request handshake; request_address passes generator_address through
//   response_valid         one single-cycle response per accepted request
//   busy, done             run in progress / one-cycle end-of-run pulse
//   aborted, error         sticky run status, cleared on an accepted start
//   issued_count           requests accepted in the current or last run
module injection_sequencer #(
    parameter int ADDRESS_WIDTH   = 48,
    parameter int COUNT_WIDTH     = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNT_WIDTH-1:0]   transaction_count,
    output logic                     generator_initialize,
    output logic                     generator_enable,
    input  logic [ADDRESS_WIDTH-1:0] generator_address,
    output logic                     request_valid,
    input  logic                     request_ready,
    output logic [ADDRESS_WIDTH-1:0] request_address,
    input  logic                     response_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     error,
    output logic [COUNT_WIDTH-1:0]   issued_count
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic                   valid_q, valid_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   aborted_q, aborted_d;
    logic                   error_q, error_d;
    logic                   done_q, done_d;
    logic                   handshake, retire, underflow, hold, raise, start_run, active;

    always_comb begin
        handshake     = valid_q & request_ready;
        retire        = response_valid & (outstanding_q != '0);
        underflow     = response_valid & (outstanding_q == '0);
        start_run     = (state_q == IDLE) & start & (transaction_count != '0);
        active        = (state_q == INIT) | (state_q == ISSUE) | (state_q == DRAIN);
        hold          = valid_q & ~request_ready;
        count_d       = start_run ? transaction_count : count_q;
        issued_d      = start_run ? '0 : issued_q + COUNT_WIDTH'(handshake);
        outstanding_d = outstanding_q + OW'(handshake) - OW'(retire);
        abort_pend_d  = start_run ? 1'b0 : abort_pend_q | (abort & active);
        aborted_d     = start_run ? 1'b0 : aborted_q | ((state_q == FINISH) & abort_pend_q);
        // A stray response in the start cycle still counts against the new run.
        error_d       = (error_q & ~start_run) | underflow;
        done_d        = ((state_q == IDLE) & start & (transaction_count == '0)) |
                        ((state_q == DRAIN) & (outstanding_q == '0));
        // Raise a new request only if the post-edge counters still leave room.
        raise         = (issued_d < count_q) & (outstanding_d < MAX_OUT) & ~abort_pend_d;
        valid_d       = 1'b0;
        state_d       = state_q;
        case (state_q)
            IDLE:    state_d = start_run ? INIT : IDLE;
            INIT: begin
                state_d = ISSUE;
                valid_d = raise;
            end
            ISSUE: begin
                valid_d = hold | raise;
                state_d = ((issued_d == count_q) || (abort_pend_d && !hold)) ? DRAIN : ISSUE;
            end
            DRAIN:   state_d = (outstanding_q == '0) ? FINISH : DRAIN;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            count_q       <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            valid_q       <= 1'b0;
            abort_pend_q  <= 1'b0;
            aborted_q     <= 1'b0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            valid_q       <= valid_d;
            abort_pend_q  <= abort_pend_d;
            aborted_q     <= aborted_d;
            error_q       <= error_d;
            done_q        <= done_d;
        end
    end

    assign generator_initialize = state_q == INIT;
    assign generator_enable     = handshake;
    assign request_valid        = valid_q;
    assign request_address      = generator_address;
    assign busy                 = state_q != IDLE;
    assign done                 = done_q;
    assign aborted              = aborted_q;
    assign error                = error_q;
    assign issued_count         = issued_q;
endmodule

// File: tb/tb_injection_sequencer.sv
// tb_injection_sequencer: directed vector table plus hand-written corner sequences.
module tb_injection_sequencer;
    localparam int AW = 48;
    localparam int CW = 32;
    localparam logic [AW-1:0] SEED   = 48'h0000_1234_0000;
    localparam logic [AW-1:0] STRIDE = 48'h40;

    typedef struct {
        int count;
        int delay;
        int stall_from;
        int stall_len;
        int abort_cyc;
        int exp_issued;
        int exp_first;
        int exp_last;
        int exp_done;
        int exp_max;
        int exp_aborted;
    } vec_t;

    logic clock = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
    logic request_ready = 1'b0, response_valid = 1'b0, sel = 1'b0;
    logic [CW-1:0] transaction_count = '0;
    logic [AW-1:0] gen_addr;
    logic d2_init, d2_en, d2_valid, d2_busy, d2_done, d2_aborted, d2_error;
    logic d4_init, d4_en, d4_valid, d4_busy, d4_done, d4_aborted, d4_error;
    logic [AW-1:0] d2_addr, d4_addr;
    logic [CW-1:0] d2_issued, d4_issued;
    logic s_init, s_en, s_valid, s_busy, s_done, s_aborted, s_error;
    logic [AW-1:0] s_addr;
    logic [CW-1:0] s_issued;

    int n_cmp = 0, n_bad = 0;
    int cyc, n_init, init_cyc, n_hs, first_hs, last_hs, n_en, en_bad, n_done, done_cyc;
    int busy_cnt, hold_bad, out_m, max_out, resp_delay;
    logic [AW-1:0] first_addr, last_addr, prev_addr;
    logic prev_held;
    bit sched [0:511];
    vec_t vecs [5];

    always #5 clock = ~clock;

    injection_sequencer #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW), .MAX_OUTSTANDING(2)) dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .transaction_count(transaction_count),
        .generator_initialize(d2_init), .generator_enable(d2_en), .generator_address(gen_addr),
        .request_valid(d2_valid), .request_ready(request_ready), .request_address(d2_addr),
        .response_valid(response_valid), .busy(d2_busy), .done(d2_done),
        .aborted(d2_aborted), .error(d2_error), .issued_count(d2_issued)
    );

    injection_sequencer #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW), .MAX_OUTSTANDING(4)) dut4 (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .transaction_count(transaction_count),
        .generator_initialize(d4_init), .generator_enable(d4_en), .generator_address(gen_addr),
        .request_valid(d4_valid), .request_ready(request_ready), .request_address(d4_addr),
        .response_valid(response_valid), .busy(d4_busy), .done(d4_done),
        .aborted(d4_aborted), .error(d4_error), .issued_count(d4_issued)
    );

    // Address generator model: seed on initialize, step by STRIDE on enable.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) gen_addr <= '0;
        else if (d2_init) gen_addr <= SEED;
        else if (d2_en) gen_addr <= gen_addr + STRIDE;
    end

    assign s_init    = sel ? d4_init    : d2_init;
    assign s_en      = sel ? d4_en      : d2_en;
    assign s_valid   = sel ? d4_valid   : d2_valid;
    assign s_busy    = sel ? d4_busy    : d2_busy;
    assign s_done    = sel ? d4_done    : d2_done;
    assign s_aborted = sel ? d4_aborted : d2_aborted;
    assign s_error   = sel ? d4_error   : d2_error;
    assign s_addr    = sel ? d4_addr    : d2_addr;
    assign s_issued  = sel ? d4_issued  : d2_issued;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; n_init = 0; init_cyc = -1; n_hs = 0; first_hs = -1; last_hs = -1;
        n_en = 0; en_bad = 0; n_done = 0; done_cyc = -1; busy_cnt = 0; hold_bad = 0;
        out_m = 0; max_out = 0; prev_held = 1'b0; prev_addr = '0;
        first_addr = '0; last_addr = '0;
        foreach (sched[i]) sched[i] = 1'b0;
        response_valid = 1'b0;
    endtask

    // Observe the current cycle at the falling edge, then advance one cycle.
    task automatic tick();
        logic hs;
        @(negedge clock);
        hs = s_valid && request_ready;
        if (s_init) begin n_init++; init_cyc = cyc; end
        if (s_busy) busy_cnt++;
        if (prev_held && !(s_valid && s_addr == prev_addr)) hold_bad++;
        if (response_valid && out_m > 0) out_m--;
        if (hs) begin
            n_hs++;
            if (first_hs < 0) begin first_hs = cyc; first_addr = s_addr; end
            last_hs = cyc;
            last_addr = s_addr;
            out_m++;
            if (resp_delay > 0) sched[cyc + resp_delay] = 1'b1;
        end
        if (out_m > max_out) max_out = out_m;
        if (s_en) n_en++;
        if (s_en != hs) en_bad++;
        if (s_done) begin n_done++; done_cyc = cyc; end
        prev_held = s_valid && !request_ready;
        prev_addr = s_addr;
        @(posedge clock);
        #1;
        cyc++;
        response_valid = (cyc < 512) ? sched[cyc] : 1'b0;
    endtask

    task automatic run(input int stall_from, input int stall_len, input int abort_cyc);
        while (cyc < 300 && !(n_done != 0 && cyc >= done_cyc + 2)) begin
            start = (cyc == 0);
            abort = (cyc == abort_cyc);
            request_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_last_addr;
        vecs[0] = '{5,   1,  0, 0, -1, 5, 2, 6,  9,  1, 0};
        vecs[1] = '{6,   10, 0, 0, -1, 6, 2, 25, 37, 2, 0};
        vecs[2] = '{3,   1,  2, 4, -1, 3, 6, 8,  11, 1, 0};
        vecs[3] = '{100, 1,  9, 2, 9,  8, 2, 11, 14, 1, 1};
        vecs[4] = '{2,   1,  0, 0, 0,  2, 2, 3,  6,  1, 0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs_d2", {d2_init, d2_en, d2_valid, d2_busy, d2_done, d2_aborted, d2_error, d2_issued}, 0);
        chk("reset_outputs_d4", {d4_init, d4_en, d4_valid, d4_busy, d4_done, d4_aborted, d4_error, d4_issued}, 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("post_reset_idle", {d2_busy, d2_valid, d2_done, d2_issued}, 0);

        for (int i = 0; i < 5; i++) begin
            clear_obs();
            resp_delay = vecs[i].delay;
            transaction_count = CW'(vecs[i].count);
            run(vecs[i].stall_from, vecs[i].stall_len, vecs[i].abort_cyc);
            exp_last_addr = SEED + STRIDE * AW'(vecs[i].exp_issued - 1);
            chk($sformatf("v%0d_issued", i), s_issued, vecs[i].exp_issued);
            chk($sformatf("v%0d_handshakes", i), n_hs, vecs[i].exp_issued);
            chk($sformatf("v%0d_enables", i), n_en, vecs[i].exp_issued);
            chk($sformatf("v%0d_enable_bad", i), en_bad, 0);
            chk($sformatf("v%0d_init_pulses", i), n_init, 1);
            chk($sformatf("v%0d_init_cycle", i), init_cyc, 1);
            chk($sformatf("v%0d_first_hs", i), first_hs, vecs[i].exp_first);
            chk($sformatf("v%0d_last_hs", i), last_hs, vecs[i].exp_last);
            chk($sformatf("v%0d_first_addr", i), first_addr, SEED);
            chk($sformatf("v%0d_last_addr", i), last_addr, exp_last_addr);
            chk($sformatf("v%0d_done_pulses", i), n_done, 1);
            chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
            chk($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_done);
            chk($sformatf("v%0d_max_outstanding", i), max_out, vecs[i].exp_max);
            chk($sformatf("v%0d_hold_bad", i), hold_bad, 0);
            chk($sformatf("v%0d_aborted", i), s_aborted, vecs[i].exp_aborted);
            chk($sformatf("v%0d_error", i), s_error, 0);
            chk($sformatf("v%0d_busy_end", i), s_busy, 0);
        end

        // Zero-length run, then a stray response, then a clearing start.
        clear_obs();
        resp_delay = 1;
        transaction_count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("zero_done_pulses", n_done, 1);
        chk("zero_done_cycle", done_cyc, 1);
        chk("zero_busy_cycles", busy_cnt, 0);
        chk("zero_error_before", s_error, 0);
        response_valid = 1'b1;
        tick();
        chk("stray_response_error", s_error, 1);
        tick();
        chk("error_sticky", s_error, 1);
        clear_obs();
        transaction_count = CW'(1);
        request_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("error_cleared_on_start", s_error, 0);
        run(0, 0, -1);
        chk("single_done_cycle", done_cyc, 5);
        chk("single_issued", s_issued, 1);
        chk("single_error", s_error, 0);

        // Reset in the middle of a run with three requests outstanding.
        sel = 1'b1;
        resetn = 1'b0;
        request_ready = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        clear_obs();
        resp_delay = 0;
        transaction_count = CW'(10);
        while (cyc < 5) begin
            start = (cyc == 0);
            request_ready = 1'b1;
            tick();
        end
        start = 1'b0;
        request_ready = 1'b0;
        @(negedge clock);
        chk("midrun_issued", s_issued, 3);
        chk("midrun_busy", s_busy, 1);
        chk("midrun_valid_held", s_valid, 1);
        #1 resetn = 1'b0;
        #1;
        chk("midrun_reset_outputs", {d4_init, d4_en, d4_valid, d4_busy, d4_done, d4_aborted, d4_error, d4_issued}, 0);
        chk("midrun_reset_address", d4_addr, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        clear_obs();
        resp_delay = 1;
        repeat (3) tick();
        chk("after_reset_no_done", n_done, 0);
        chk("after_reset_idle", busy_cnt, 0);
        clear_obs();
        transaction_count = CW'(2);
        run(0, 0, -1);
        chk("rerun_init_cycle", init_cyc, 1);
        chk("rerun_first_hs", first_hs, 2);
        chk("rerun_handshakes", n_hs, 2);
        chk("rerun_done_cycle", done_cyc, 6);
        chk("rerun_issued", s_issued, 2);
        chk("rerun_error", s_error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
